// File: rtl/aes_pkg.sv
// Shared types and constants for the CBC decryption controller and its padding checker.
package aes_pkg;

    localparam int BLOCK_W   = 128;
    localparam int BYTES     = 16;
    localparam int BYTE_W    = 8;
    localparam int LAST_BYTE = BYTES - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Byte 0 is the most significant byte of the block.
    function automatic logic [BYTE_W-1:0] get_byte(input logic [BLOCK_W-1:0] blk, input int idx);
        return blk[BLOCK_W-1-BYTE_W*idx -: BYTE_W];
    endfunction

endpackage

// File: rtl/pkcs7_check.sv
// Combinational PKCS#7 padding check; non-final blocks always report 16 valid bytes.
module pkcs7_check
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] i_block,
    input  logic               i_is_last,
    output logic [4:0]         o_bytes,
    output logic               o_pad_err
);

    logic [BYTE_W-1:0] w_pad;
    logic              w_ok;

    assign w_pad = get_byte(i_block, LAST_BYTE);

    always_comb begin
        w_ok = (w_pad >= 8'd1) && (w_pad <= 8'(BYTES));
        // Byte i lies inside the pad region when i >= 16 - p.
        for (int i = 0; i < BYTES; i++) begin
            if ((BYTES - i <= int'(w_pad)) && (get_byte(i_block, i) != w_pad)) begin
                w_ok = 1'b0;
            end
        end
    end

    always_comb begin
        o_bytes   = 5'(BYTES);
        o_pad_err = 1'b0;
        if (i_is_last) begin
            if (w_ok) begin
                o_bytes = 5'(BYTES) - w_pad[4:0];
            end else begin
                o_pad_err = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cbc_dec_ctrl.sv
// CBC-mode decryption controller: drives inv_aes, chains its result with the
// previous ciphertext block and checks/strips PKCS#7 padding on the final block.
module cbc_dec_ctrl
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic               clk,
    input  logic               rest,
    input  logic [BLOCK_W-1:0] iv_in,
    input  logic               iv_load,
    input  logic [BLOCK_W-1:0] ct_in,
    input  logic               ct_valid,
    input  logic               ct_last,
    output logic               ct_ready,
    output logic [BLOCK_W-1:0] pt_out,
    output logic               pt_valid,
    output logic               pt_last,
    output logic [4:0]         pt_bytes,
    input  logic               pt_ready,
    output logic               pad_err,
    output logic               timeout_err,
    output logic               core_start,
    output logic [BLOCK_W-1:0] core_ct,
    input  logic [BLOCK_W-1:0] core_pt,
    input  logic               core_done,
    output state_t             dbg_state
);

    // Both streams are valid/ready: a block moves on a rising edge where valid
    // and ready are both high; the source holds its payload while valid waits.

    state_t             r_state, w_state_nxt;
    logic               r_iv_loaded, r_last;
    logic [BLOCK_W-1:0] r_prev_ct, r_core_ct, r_pt_out;
    logic               r_pt_valid, r_pt_last, r_pad_err, r_timeout_err;
    logic [4:0]         r_pt_bytes;
    logic [CNT_W-1:0]   r_cnt;

    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [BLOCK_W-1:0] w_xor;
    logic [4:0]         w_bytes;
    logic               w_pad_err;
    logic               w_ct_hs, w_done_hit, w_timeout_hit, w_pt_hs;

    assign w_xor     = core_pt ^ r_prev_ct;
    assign w_cnt_nxt = r_cnt + CNT_W'(1);

    pkcs7_check u_pkcs7 (
        .i_block   (w_xor),
        .i_is_last (r_last),
        .o_bytes   (w_bytes),
        .o_pad_err (w_pad_err)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_ct_hs       = 1'b0;
        w_done_hit    = 1'b0;
        w_timeout_hit = 1'b0;
        w_pt_hs       = 1'b0;
        case (r_state)
            IDLE: begin
                if (ct_ready && ct_valid) begin
                    w_ct_hs     = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: w_state_nxt = WAIT;
            WAIT: begin
                // r_cnt+1 counts cycles since core_start; done wins a tie with timeout.
                if (core_done) begin
                    w_done_hit  = 1'b1;
                    w_state_nxt = OUT;
                end else if (w_cnt_nxt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout_hit = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            OUT: begin
                if (pt_ready) begin
                    w_pt_hs     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            r_state       <= IDLE;
            r_iv_loaded   <= 1'b0;
            r_last        <= 1'b0;
            r_prev_ct     <= '0;
            r_core_ct     <= '0;
            r_pt_out      <= '0;
            r_pt_valid    <= 1'b0;
            r_pt_last     <= 1'b0;
            r_pt_bytes    <= '0;
            r_pad_err     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && iv_load) begin
                r_prev_ct   <= iv_in;
                r_iv_loaded <= 1'b1;
            end
            if (w_ct_hs) begin
                r_core_ct <= ct_in;
                r_last    <= ct_last;
            end
            if (r_state == START) begin
                r_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= w_cnt_nxt;
            end
            if (w_done_hit) begin
                r_pt_out   <= w_xor;
                r_prev_ct  <= r_core_ct;
                r_pt_last  <= r_last;
                r_pt_bytes <= w_bytes;
                r_pad_err  <= w_pad_err;
                r_pt_valid <= 1'b1;
            end
            if (w_timeout_hit) begin
                r_timeout_err <= 1'b1;
                r_iv_loaded   <= 1'b0;
            end
            if (w_pt_hs) begin
                r_pt_valid <= 1'b0;
                if (r_pt_last) begin
                    r_iv_loaded <= 1'b0;
                end
            end
        end
    end

    assign ct_ready    = (r_state == IDLE) && r_iv_loaded && !iv_load;
    assign core_start  = (r_state == START);
    assign core_ct     = r_core_ct;
    assign pt_out      = r_pt_out;
    assign pt_valid    = r_pt_valid;
    assign pt_last     = r_pt_last;
    assign pt_bytes    = r_pt_bytes;
    assign pad_err     = r_pad_err;
    assign timeout_err = r_timeout_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_cbc_dec_ctrl.sv
// Self-checking bench for cbc_dec_ctrl with a behavioural inv_aes stand-in.
module tb_cbc_dec_ctrl;
    import aes_pkg::*;

    localparam logic [127:0] KAT_IV = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_C1 = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] KAT_C2 = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] KAT_P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] KAT_P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    // Raw AES-128 decryptions of C1 and C2 under key 2b7e1516...: P1^IV and P2^C1.
    localparam logic [127:0] KAT_D1 = 128'h6bc0bce12a459991e134741a7f9e1925;
    localparam logic [127:0] KAT_D2 = 128'hd86421fb9f1a1eda505ee1375746972c;

    logic         clk = 1'b0;
    logic         rest;
    logic [127:0] iv_in, ct_in, pt_out, core_ct;
    logic [127:0] core_pt = '0;
    logic         iv_load, ct_valid, ct_last, ct_ready;
    logic         pt_valid, pt_last, pt_ready, pad_err, timeout_err, core_start;
    logic         core_done = 1'b0;
    logic [4:0]   pt_bytes;
    state_t       dbg_state;

    always #5 clk = ~clk;

    cbc_dec_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .clk(clk), .rest(rest), .iv_in(iv_in), .iv_load(iv_load),
        .ct_in(ct_in), .ct_valid(ct_valid), .ct_last(ct_last), .ct_ready(ct_ready),
        .pt_out(pt_out), .pt_valid(pt_valid), .pt_last(pt_last), .pt_bytes(pt_bytes),
        .pt_ready(pt_ready), .pad_err(pad_err), .timeout_err(timeout_err),
        .core_start(core_start), .core_ct(core_ct), .core_pt(core_pt),
        .core_done(core_done), .dbg_state(dbg_state)
    );

    int total = 0;
    int bad = 0;
    logic [134:0] exp_q[$];

    typedef struct {
        logic [127:0] iv;
        logic [127:0] ct;
        logic         last;
        logic [127:0] pt;
        logic [4:0]   nbytes;
        logic         perr;
    } vec_t;
    vec_t vecs[10];

    // inv_aes stand-in: known KAT answers, identity otherwise, or never done.
    int           core_mode = 0;
    int           core_cnt = 0;
    logic         core_busy = 1'b0;
    logic [127:0] core_lat = '0;

    function automatic logic [127:0] core_ref(input logic [127:0] c);
        if (c == KAT_C1) return KAT_D1;
        if (c == KAT_C2) return KAT_D2;
        return c;
    endfunction

    always @(negedge clk) begin
        if (rest) begin
            core_busy = 1'b0;
            core_done = 1'b0;
            core_cnt  = 0;
        end else begin
            core_done = 1'b0;
            if (core_start && core_mode == 0) begin
                core_busy = 1'b1;
                core_cnt  = 0;
                core_lat  = core_ct;
            end else if (core_busy) begin
                core_cnt++;
                if (core_cnt == 13) begin
                    core_done = 1'b1;
                    core_pt   = core_ref(core_lat);
                    core_busy = 1'b0;
                end
            end
        end
    end

    function automatic logic [134:0] mk_exp(input logic [127:0] pt, input logic last,
                                            input logic [4:0] nb, input logic perr);
        return {pt, last, nb, perr};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic load_iv(input logic [127:0] v);
        @(negedge clk);
        iv_in   = v;
        iv_load = 1'b1;
        @(posedge clk);
        #1 iv_load = 1'b0;
    endtask

    task automatic send(input logic [127:0] ct, input logic last, input logic [134:0] e);
        int n = 0;
        @(negedge clk);
        while (!ct_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ct_ready) begin
            total++;
            bad++;
            $display("FAIL send_wait: ct_ready stayed 0 for %0d cycles, want 1", n);
            return;
        end
        ct_in    = ct;
        ct_last  = last;
        ct_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        ct_valid = 1'b0;
        ct_last  = 1'b0;
        chk("core_start_after_hs", core_start, 1'b1);
        chk("core_ct_latched", core_ct, ct);
    endtask

    task automatic recv(input int hold);
        int n = 0;
        logic [134:0] e;
        logic [127:0] held;
        @(negedge clk);
        while (!pt_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!pt_valid) begin
            total++;
            bad++;
            $display("FAIL recv_wait: pt_valid stayed 0 for %0d cycles, want 1", n);
            return;
        end
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL recv_unexpected: got pt %h want no block", pt_out);
        end else begin
            e = exp_q.pop_front();
            chk("pt_out", pt_out, e[134:7]);
            chk("pt_last", pt_last, e[6]);
            chk("pt_bytes", pt_bytes, e[5:1]);
            chk("pad_err", pad_err, e[0]);
        end
        held = pt_out;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("bp_pt_stable", pt_out, held);
            chk("bp_pt_valid", pt_valid, 1'b1);
            chk("bp_ct_ready", ct_ready, 1'b0);
        end
        pt_ready = 1'b1;
        @(posedge clk);
        #1 pt_ready = 1'b0;
        chk("pt_valid_drop", pt_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test want finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic pt_seen;

        vecs[0] = '{'0, 128'h41424344454647484950515204040404, 1'b1,
                    128'h41424344454647484950515204040404, 5'd12, 1'b0};
        vecs[1] = '{'0, 128'h41424344454647484950515253040404, 1'b1,
                    128'h41424344454647484950515253040404, 5'd16, 1'b1};
        vecs[2] = '{'0, 128'h000102030405060708090a0b0c0d0305, 1'b1,
                    128'h000102030405060708090a0b0c0d0305, 5'd16, 1'b1};
        vecs[3] = '{'0, 128'hffeeddccbbaa99887766554433221100, 1'b1,
                    128'hffeeddccbbaa99887766554433221100, 5'd16, 1'b1};
        vecs[4] = '{'0, {16{8'h10}}, 1'b1, {16{8'h10}}, 5'd0, 1'b0};
        vecs[5] = '{'0, 128'h00112233445566778899aabbccddee01, 1'b1,
                    128'h00112233445566778899aabbccddee01, 5'd15, 1'b0};
        vecs[6] = '{'0, {16{8'h11}}, 1'b1, {16{8'h11}}, 5'd16, 1'b1};
        vecs[7] = '{{128{1'b1}}, 128'h0123456789abcdeffedcba9876543210, 1'b0,
                    128'hfedcba98765432100123456789abcdef, 5'd16, 1'b0};
        vecs[8] = '{128'h00000000000000000000000000030303,
                    128'haabbccddeeff00112233445566000000, 1'b1,
                    128'haabbccddeeff00112233445566030303, 5'd13, 1'b0};
        vecs[9] = '{'0, 128'h41424344454647484950515204040404, 1'b0,
                    128'h41424344454647484950515204040404, 5'd16, 1'b0};

        rest = 1'b1; iv_in = '0; iv_load = 1'b0; ct_in = '0; ct_valid = 1'b0;
        ct_last = 1'b0; pt_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", dbg_state, IDLE);
        chk("rst_ct_ready", ct_ready, 1'b0);
        chk("rst_pt_valid", pt_valid, 1'b0);
        chk("rst_pt_out", pt_out, '0);
        chk("rst_pt_bytes", pt_bytes, '0);
        chk("rst_timeout", timeout_err, 1'b0);
        chk("rst_core_start", core_start, 1'b0);
        chk("rst_core_ct", core_ct, '0);
        @(negedge clk);
        rest = 1'b0;

        // SP800-38A F.2.1 chain; C2 only decrypts correctly if chained on C1.
        load_iv(KAT_IV);
        send(KAT_C1, 1'b0, mk_exp(KAT_P1, 1'b0, 5'd16, 1'b0));
        recv(0);
        send(KAT_C2, 1'b0, mk_exp(KAT_P2, 1'b0, 5'd16, 1'b0));
        recv(0);

        for (int i = 0; i < 10; i++) begin
            load_iv(vecs[i].iv);
            send(vecs[i].ct, vecs[i].last,
                 mk_exp(vecs[i].pt, vecs[i].last, vecs[i].nbytes, vecs[i].perr));
            recv(0);
            @(negedge clk);
            chk("ct_ready_after_msg", ct_ready, !vecs[i].last);
        end

        // Backpressure: pt_ready held low for 10 cycles.
        load_iv('0);
        send(128'hc0ffee00c0ffee00c0ffee00c0ffee00, 1'b0,
             mk_exp(128'hc0ffee00c0ffee00c0ffee00c0ffee00, 1'b0, 5'd16, 1'b0));
        recv(10);

        // iv_load and ct_valid together: the IV wins and the block waits.
        @(negedge clk);
        iv_in = 128'h00000000000000000000000000010203; iv_load = 1'b1;
        ct_in = 128'h0f0e0d0c0b0a09080706050403020100; ct_valid = 1'b1; ct_last = 1'b1;
        #1 chk("ct_ready_during_ivload", ct_ready, 1'b0);
        @(posedge clk);
        #1 chk("no_hs_on_ivload", dbg_state, IDLE);
        iv_load = 1'b0;
        exp_q.push_back(mk_exp(128'h0f0e0d0c0b0a09080706050403030303, 1'b1, 5'd13, 1'b0));
        @(posedge clk);
        #1;
        ct_valid = 1'b0;
        ct_last  = 1'b0;
        chk("hs_after_ivload", dbg_state, START);
        recv(0);

        // Reset while a block is inside the core.
        load_iv('0);
        send(128'h1234, 1'b0, mk_exp(128'h1234, 1'b0, 5'd16, 1'b0));
        repeat (3) @(negedge clk);
        chk("in_wait", dbg_state, WAIT);
        rest = 1'b1;
        @(posedge clk);
        #1;
        chk("wrst_state", dbg_state, IDLE);
        chk("wrst_pt_out", pt_out, '0);
        chk("wrst_pt_valid", pt_valid, 1'b0);
        chk("wrst_core_ct", core_ct, '0);
        chk("wrst_ct_ready", ct_ready, 1'b0);
        chk("wrst_pt_last", pt_last, 1'b0);
        chk("wrst_pad_err", pad_err, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rest = 1'b0;
        exp_q.delete();
        pt_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (pt_valid) pt_seen = 1'b1;
        end
        chk("wrst_no_pt", pt_seen, 1'b0);

        // Core that never answers.
        core_mode = 1;
        load_iv('0);
        send(128'h5555, 1'b0, mk_exp(128'h5555, 1'b0, 5'd16, 1'b0));
        exp_q.delete();
        n = 0;
        pt_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (pt_valid) pt_seen = 1'b1;
            if (timeout_err || n >= 200) break;
            n++;
        end
        chk("timeout_cycles", n, 64);
        chk("timeout_flag", timeout_err, 1'b1);
        chk("timeout_no_pt", pt_seen, 1'b0);
        chk("timeout_state", dbg_state, IDLE);
        chk("timeout_ct_ready", ct_ready, 1'b0);
        repeat (5) @(negedge clk);
        chk("timeout_sticky", timeout_err, 1'b1);
        core_mode = 0;
        rest = 1'b1;
        @(posedge clk);
        #1 chk("timeout_cleared", timeout_err, 1'b0);
        @(negedge clk);
        rest = 1'b0;

        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
